// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: turns each AC snoop into a single cache lookup/update,
// answers on CR and, when data is transferred, streams the line on CD.
module ace_snoop_responder #(
  parameter int AddrWidth       = 64,
  parameter int DataWidth       = 64,
  parameter int DcacheLineWidth = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [DataWidth-1:0]       cd_data_o,
  output logic                       cd_last_o,
  output logic                       cache_req_o,
  input  logic                       cache_gnt_i,
  output logic [AddrWidth-1:0]       cache_addr_o,
  output logic [1:0]                 cache_op_o,
  input  logic                       cache_rvalid_i,
  input  logic                       cache_hit_i,
  input  logic                       cache_dirty_i,
  input  logic                       cache_shared_i,
  input  logic [DcacheLineWidth-1:0] cache_data_i
);

  localparam int NBeats     = DcacheLineWidth / DataWidth;
  localparam int BeatWidth  = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam int OffsetBits = $clog2(DcacheLineWidth / 8);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_RSP,
    RESP,
    DATA
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE              = 2'd0,
    OP_MAKE_SHARED_CLEAN = 2'd1,
    OP_INVALIDATE        = 2'd2
  } cache_op_e;

  state_e                     state_q, state_d;
  logic [AddrWidth-1:0]       addr_q;
  logic [3:0]                 snoop_q;
  logic [4:0]                 resp_q;
  logic [DcacheLineWidth-1:0] line_q;
  logic [BeatWidth-1:0]       beat_q;

  function automatic logic snoop_supported(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1000, 4'b1001, 4'b1101: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic cache_op_e snoop_op(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b1000: return OP_MAKE_SHARED_CLEAN;
      4'b0111, 4'b1001, 4'b1101:          return OP_INVALIDATE;
      default:                            return OP_NONE;
    endcase
  endfunction

  // CRRESP = {WasUnique, IsShared, PassDirty, Error, DataTransfer}; a miss collapses to zero
  function automatic logic [4:0] snoop_resp(input logic [3:0] code, input logic hit,
                                            input logic dirty, input logic shared);
    logic dt;
    logic pd;
    logic is_shared;
    dt        = hit;
    pd        = hit & dirty;
    is_shared = hit;
    case (code)
      4'b0000:          pd = 1'b0;
      4'b0111, 4'b1001: is_shared = 1'b0;
      4'b1000:          dt = hit & dirty;
      4'b1101: begin
        dt        = 1'b0;
        pd        = 1'b0;
        is_shared = 1'b0;
      end
      default: ;
    endcase
    return {hit & ~shared, is_shared, pd, 1'b0, dt};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ac_ready_o   = 1'b0;
    cr_valid_o   = 1'b0;
    cr_resp_o    = '0;
    cd_valid_o   = 1'b0;
    cd_data_o    = '0;
    cd_last_o    = 1'b0;
    cache_req_o  = 1'b0;
    cache_addr_o = '0;
    cache_op_o   = OP_NONE;
    unique case (state_q)
      IDLE: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) state_d = snoop_supported(ac_snoop_i) ? LOOKUP : RESP;
      end
      LOOKUP: begin
        cache_req_o  = 1'b1;
        cache_addr_o = (addr_q >> OffsetBits) << OffsetBits;
        cache_op_o   = snoop_op(snoop_q);
        if (cache_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (cache_rvalid_i) state_d = RESP;
      end
      RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = resp_q;
        if (cr_ready_i) state_d = resp_q[0] ? DATA : IDLE;
      end
      DATA: begin
        cd_valid_o = 1'b1;
        cd_data_o  = line_q[DataWidth-1:0];
        cd_last_o  = (beat_q == BeatWidth'(NBeats - 1));
        if (cd_ready_i && cd_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is shifted down on each accepted beat so the current beat always sits at the bottom
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ac_valid_i) begin
            addr_q  <= ac_addr_i;
            snoop_q <= ac_snoop_i;
            beat_q  <= '0;
            resp_q  <= snoop_supported(ac_snoop_i) ? 5'b00000 : 5'b00010;
          end
        end
        WAIT_RSP: begin
          if (cache_rvalid_i) begin
            resp_q <= snoop_resp(snoop_q, cache_hit_i, cache_dirty_i, cache_shared_i);
            line_q <= cache_data_i;
          end
        end
        DATA: begin
          if (cd_ready_i) begin
            beat_q <= beat_q + 1'b1;
            line_q <= line_q >> DataWidth;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Randomized self-checking bench for ace_snoop_responder: the bench plays the AC master,
// the CR/CD sink and the cache, and checks every output against a rule-based model.
module tb_ace_snoop_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 128;
  localparam int NB = LW / DW;

  logic          clk;
  logic          rst;
  logic          ac_valid;
  logic          ac_ready;
  logic [AW-1:0] ac_addr;
  logic [3:0]    ac_snoop;
  logic          cr_valid;
  logic          cr_ready;
  logic [4:0]    cr_resp;
  logic          cd_valid;
  logic          cd_ready;
  logic [DW-1:0] cd_data;
  logic          cd_last;
  logic          cache_req;
  logic          cache_gnt;
  logic [AW-1:0] cache_addr;
  logic [1:0]    cache_op;
  logic          cache_rvalid;
  logic          cache_hit;
  logic          cache_dirty;
  logic          cache_shared;
  logic [LW-1:0] cache_data;

  int tests_run = 0;
  int tests_failed = 0;

  ace_snoop_responder #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .DcacheLineWidth(LW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ac_valid_i(ac_valid),
    .ac_ready_o(ac_ready),
    .ac_addr_i(ac_addr),
    .ac_snoop_i(ac_snoop),
    .cr_valid_o(cr_valid),
    .cr_ready_i(cr_ready),
    .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid),
    .cd_ready_i(cd_ready),
    .cd_data_o(cd_data),
    .cd_last_o(cd_last),
    .cache_req_o(cache_req),
    .cache_gnt_i(cache_gnt),
    .cache_addr_o(cache_addr),
    .cache_op_o(cache_op),
    .cache_rvalid_i(cache_rvalid),
    .cache_hit_i(cache_hit),
    .cache_dirty_i(cache_dirty),
    .cache_shared_i(cache_shared),
    .cache_data_i(cache_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Snoop semantics: which codes are served, what they do to the line, and what they report
  function automatic void ref_model(input logic [3:0] code, input logic h, input logic d,
                                    input logic s, output bit ok, output logic [1:0] op,
                                    output logic [4:0] resp);
    bit wu, is_sh, pd, dt;
    ok = 1'b1;
    wu = h && !s;
    case (code)
      4'd0:             begin op = 2'd0; dt = h; pd = 1'b0;   is_sh = h;    end
      4'd1, 4'd2, 4'd3: begin op = 2'd1; dt = h; pd = h && d; is_sh = h;    end
      4'd7, 4'd9:       begin op = 2'd2; dt = h; pd = h && d; is_sh = 1'b0; end
      4'd8:             begin op = 2'd1; dt = h && d; pd = h && d; is_sh = h; end
      4'd13:            begin op = 2'd2; dt = 1'b0; pd = 1'b0; is_sh = 1'b0; end
      default: begin
        ok = 1'b0; op = 2'd0; dt = 1'b0; pd = 1'b0; is_sh = 1'b0; wu = 1'b0;
      end
    endcase
    resp = ok ? {wu, is_sh, pd, 1'b0, dt} : 5'b00010;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_ctrl"}, {cr_valid, cr_resp, cd_valid, cd_last, cache_req, cache_op}, '0);
    check_output({tag, "_cd_data"}, cd_data, '0);
    check_output({tag, "_cache_addr"}, cache_addr, '0);
    check_output({tag, "_ac_ready"}, ac_ready, 1'b1);
  endtask

  // One complete snoop; abort_beat >= 0 asserts reset while that CD beat is being offered
  task automatic apply_stimulus(input logic [3:0] code, input logic [63:0] addr, input logic h,
                                input logic d, input logic s, input logic [127:0] line,
                                input bit stalls, input int abort_beat);
    bit ok;
    logic [1:0] op;
    logic [4:0] resp;
    int n;
    ref_model(code, h, d, s, ok, op, resp);
    @(negedge clk);
    check_output("ac_ready_idle", ac_ready, 1'b1);
    ac_valid = 1'b1;
    ac_addr  = addr;
    ac_snoop = code;
    @(negedge clk);
    ac_valid = 1'b0;
    ac_addr  = rand64();
    ac_snoop = 4'($urandom);
    check_output("ac_ready_busy", ac_ready, 1'b0);
    if (ok) begin
      n = stalls ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i <= n; i++) begin
        check_output("cache_req", cache_req, 1'b1);
        check_output("cache_addr", cache_addr, {addr[63:4], 4'h0});
        check_output("cache_op", cache_op, op);
        if (i == n) cache_gnt = 1'b1;
        @(negedge clk);
        cache_gnt = 1'b0;
      end
      check_output("cache_req_after_gnt", cache_req, 1'b0);
      n = stalls ? int'($urandom_range(0, 3)) : 0;
      repeat (n) begin
        check_output("cr_valid_wait", cr_valid, 1'b0);
        @(negedge clk);
      end
      cache_rvalid = 1'b1;
      cache_hit    = h;
      cache_dirty  = d;
      cache_shared = s;
      cache_data   = line;
      @(negedge clk);
      cache_rvalid = 1'b0;
      cache_hit    = 1'($urandom);
      cache_dirty  = 1'($urandom);
      cache_shared = 1'($urandom);
      cache_data   = {rand64(), rand64()};
    end else begin
      check_output("no_cache_req", cache_req, 1'b0);
    end
    n = stalls ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i <= n; i++) begin
      check_output("cr_valid", cr_valid, 1'b1);
      check_output("cr_resp", cr_resp, resp);
      check_output("cd_valid_in_resp", cd_valid, 1'b0);
      cache_rvalid = stalls ? 1'($urandom) : 1'b0;
      cache_hit    = 1'($urandom);
      cache_data   = {rand64(), rand64()};
      if (i == n) cr_ready = 1'b1;
      @(negedge clk);
      cr_ready     = 1'b0;
      cache_rvalid = 1'b0;
    end
    if (resp[0]) begin
      for (int k = 0; k < NB; k++) begin
        n = stalls ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i <= n; i++) begin
          if (k == abort_beat) begin
            rst = 1'b1;
            #1;
            check_idle_outputs("rst_async");
            @(posedge clk);
            #1;
            check_idle_outputs("rst_edge");
            @(negedge clk);
            rst = 1'b0;
            return;
          end
          check_output("cd_valid", cd_valid, 1'b1);
          check_output("cd_data", cd_data, line[k*DW +: DW]);
          check_output("cd_last", cd_last, (k == NB - 1));
          check_output("cr_valid_in_data", cr_valid, 1'b0);
          if (i == n) cd_ready = 1'b1;
          @(negedge clk);
          cd_ready = 1'b0;
        end
      end
    end
    check_idle_outputs("done");
  endtask

  initial begin
    logic [3:0] code;
    rst          = 1'b1;
    ac_valid     = 1'b0;
    ac_addr      = '0;
    ac_snoop     = '0;
    cr_ready     = 1'b0;
    cd_ready     = 1'b0;
    cache_gnt    = 1'b0;
    cache_rvalid = 1'b0;
    cache_hit    = 1'b0;
    cache_dirty  = 1'b0;
    cache_shared = 1'b0;
    cache_data   = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");

    apply_stimulus(4'b0001, 64'h1040, 1'b1, 1'b1, 1'b0,
                   {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0, -1);
    apply_stimulus(4'b0000, 64'h2_0078, 1'b0, 1'b1, 1'b0, {rand64(), rand64()}, 1'b0, -1);
    apply_stimulus(4'b1101, 64'h3000, 1'b1, 1'b0, 1'b1, {rand64(), rand64()}, 1'b0, -1);
    apply_stimulus(4'b1110, 64'h4000, 1'b1, 1'b1, 1'b0, {rand64(), rand64()}, 1'b0, -1);
    apply_stimulus(4'b1000, 64'h5010, 1'b1, 1'b0, 1'b0, {rand64(), rand64()}, 1'b1, -1);
    apply_stimulus(4'b1000, 64'h5020, 1'b1, 1'b1, 1'b1, {rand64(), rand64()}, 1'b1, -1);

    for (int t = 0; t < 60; t++) begin
      code = 4'($urandom_range(0, 15));
      apply_stimulus(code, rand64(), 1'($urandom), 1'($urandom), 1'($urandom),
                     {rand64(), rand64()}, 1'b1, -1);
    end

    apply_stimulus(4'b0111, 64'h6040, 1'b1, 1'b1, 1'b0, {rand64(), rand64()}, 1'b0, 1);
    apply_stimulus(4'b0010, 64'h7080, 1'b1, 1'b0, 1'b0, {rand64(), rand64()}, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
